// File: rtl/cpu_controller_pkg.sv
// cpu_defs: shared constants for the CPU controller slice.
//   - datapath / register-number widths
//   - ALU op codes, instruction opcode/op fields, write-back selects
//   - FSM state encoding (plain localparams so legacy tools can consume it)
package cpu_defs;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_GETA   = 3'd2;
    localparam logic [2:0] S_GETB   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WREG   = 3'd5;
    localparam logic [2:0] S_WIMM   = 3'd6;

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: instruction-side handshake plus datapath control bundle.
//   instruction side : in, load, s (to controller), w (from controller)
//   datapath control : readnum, writenum, write, vsel, loada/b/c, loads,
//                      asel, ALUop, shift, sximm8, sximm5 (from controller)
// modport master = controller, modport slave = datapath / instruction source.
interface cpu_controller_if #(
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int REG_AW = cpu_defs::REG_AW
);
    logic [DATA_W-1:0] in;
    logic              load;
    logic              s;
    logic              w;
    logic [REG_AW-1:0] readnum;
    logic [REG_AW-1:0] writenum;
    logic              write;
    logic [1:0]        vsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic [1:0]        ALUop;
    logic [1:0]        shift;
    logic [DATA_W-1:0] sximm8;
    logic [DATA_W-1:0] sximm5;

    modport master (
        input  in, load, s,
        output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, ALUop, shift, sximm8, sximm5
    );

    modport slave (
        output in, load, s,
        input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, ALUop, shift, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// instr_decoder: purely combinational split of the instruction register.
//   ir      in   instruction register
//   opcode  out  ir[15:13]      op  out  ir[12:11]
//   rn      out  ir[10:8]       rd  out  ir[7:5]
//   sh      out  ir[4:3]        rm  out  ir[2:0]
//   sximm8  out  sign-extended ir[7:0]
//   sximm5  out  sign-extended ir[4:0]
module instr_decoder
    import cpu_defs::*;
(
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [REG_AW-1:0] rn,
    output logic [REG_AW-1:0] rd,
    output logic [1:0]        sh,
    output logic [REG_AW-1:0] rm,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register + multicycle FSM steering the ALU datapath.
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   bus      master side of cpu_controller_if (instruction in, w out,
//            register numbers, load strobes, write-back select, ALU controls)
// Outputs are Moore: a function of state and IR only.
//
// state  | meaning
// WAIT   | idle, w = 1, IR may be loaded, s starts execution
// DECODE | classify IR, pick first operand state (or drop illegal)
// GETA   | read Rn into A
// GETB   | read Rm into B
// EXEC   | run ALU; CMP updates status, others load C
// WREG   | write C to Rd
// WIMM   | write sximm8 to Rn
module cpu_controller
    import cpu_defs::*;
(
    input  logic               clk,
    input  logic               reset_n,
    cpu_controller_if.master   bus
);
    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [REG_AW-1:0] rn, rd, rm;
    logic [1:0]        sh;
    logic [DATA_W-1:0] sximm8, sximm5;

    instr_decoder u_dec (
        .ir     (ir_q),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    logic is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_alu;

    assign is_alu     = (opcode == OPC_ALU);
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_mvn     = is_alu && (op == OP_MVN);
    assign is_cmp     = is_alu && (op == OP_CMP);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                // IR capture and start share an edge, so DECODE sees the new word.
                if (bus.load) ir_d = bus.in;
                if (bus.s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                 state_d = S_WIMM;
                else if (is_mov_reg || is_mvn)  state_d = S_GETB;
                else if (is_alu)                state_d = S_GETA;
                else                            state_d = S_WAIT;
            end
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_EXEC;
            S_EXEC:  state_d = is_cmp ? S_WAIT : S_WREG;
            S_WREG:  state_d = S_WAIT;
            S_WIMM:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    logic              w;
    logic [REG_AW-1:0] readnum, writenum;
    logic              write, loada, loadb, loadc, loads, asel;
    logic [1:0]        vsel, alu_op;

    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        alu_op   = ALU_ADD;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                if (is_alu) alu_op = op;
                // MOV-reg is 0 + B; MVN ignores A, zeroed for a clean operand.
                asel  = is_mov_reg || is_mvn;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            S_WREG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            S_WIMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.w        = w;
    assign bus.readnum  = readnum;
    assign bus.writenum = writenum;
    assign bus.write    = write;
    assign bus.vsel     = vsel;
    assign bus.loada    = loada;
    assign bus.loadb    = loadb;
    assign bus.loadc    = loadc;
    assign bus.loads    = loads;
    assign bus.asel     = asel;
    assign bus.ALUop    = alu_op;
    assign bus.shift    = sh;
    assign bus.sximm8   = sximm8;
    assign bus.sximm5   = sximm5;
endmodule
